imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, meaning the number of instruction-memory words; it SHALL be a power of two.
REQ-002 The block SHALL have parameter AW, default 10, meaning the word-address width (log2 DEPTH).
REQ-003 clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a load.
REQ-006 in_valid  input  1  byte-stream valid.
REQ-007 in_data  input  8  program byte, big-endian within each word.
REQ-008 in_last  input  1  marks the final byte of the image; qualified by in_valid.
REQ-009 in_ready  output  1  the loader accepts a byte this cycle.
REQ-010 imem_we  output  1  instruction-memory write strobe.
REQ-011 imem_addr  output  AW  word index to write.
REQ-012 imem_wdata  output  32  assembled instruction word.
REQ-013 cpu_rst  output  1  holds the CPU in reset; active high.
REQ-014 busy  output  1  a load is in progress.
REQ-015 done  output  1  the image loaded successfully.
REQ-016 error  output  1  the image overflowed DEPTH.
REQ-017 words_loaded  output  AW+1  count of words written in the current load.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, DONE and ERR.
REQ-019 A byte SHALL be accepted only when in_valid and in_ready are both high.
REQ-020 in_ready SHALL be high only in LOAD.
REQ-021 In IDLE, DONE or ERR, start=1 SHALL move the FSM to LOAD, clear the byte counter, words_loaded and error, and set the next write address to 0.
REQ-022 start SHALL be ignored while in LOAD.
REQ-023 Byte placement: accepted byte k of a word (k=0..3) SHALL land in bits [31-8k:24-8k]; byte 0 is the MSB.
REQ-024 On acceptance of byte 3, or of any byte with in_last=1, imem_we SHALL pulse high for exactly the next cycle, with imem_addr=words_loaded and imem_wdata=assembled word.
REQ-025 Bytes missing from a partial final word SHALL be zero-filled, e.g. bytes AA,BB(last) produce word 0xAABB0000.
REQ-026 words_loaded SHALL increment in the same cycle imem_we is high.
REQ-027 Back-to-back bytes SHALL be accepted every cycle with no bubble, including during the imem_we cycle.
REQ-028 When in_last is accepted, the FSM SHALL go to DONE in the same edge that registers the final write; done SHALL rise with that final imem_we.
REQ-029 Overflow: a byte accepted while words_loaded==DEPTH SHALL send the FSM to ERR with no write; error=1, in_ready=0.
REQ-030 Because words_loaded is AW+1 bits wide, a full load of exactly DEPTH words ending in in_last SHALL reach DONE without error.
REQ-031 in_valid gaps SHALL only stall the load, with no loss of partial-word bytes.
REQ-032 cpu_rst SHALL be 0 only in DONE and 1 in every other state; it SHALL fall the cycle after the final imem_we.
REQ-033 busy SHALL be 1 in LOAD; done SHALL be 1 in DONE; error SHALL be 1 in ERR; each SHALL be 0 otherwise.
REQ-034 If start and in_valid are both high in IDLE, that byte SHALL NOT be accepted, since in_ready is 0 that cycle.

Reset
REQ-035 On rst=1 at a clock edge, the block SHALL enter IDLE with in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, words_loaded=0, byte counter=0, busy=0, done=0, error=0, cpu_rst=1.
REQ-036 A reset mid-load SHALL abandon any partial word without writing it.
REQ-037 rst SHALL take priority over start and over stream input in the same cycle.

Verification
REQ-038 Start, then bytes 3C,01,00,00,34,21,00,04(last) one per cycle -> writes [0]=0x3C010000 and [1]=0x34210004; words_loaded=2; done=1; cpu_rst=0 the following cycle.
REQ-039 Bytes AA,BB(last) -> a single write [0]=0xAABB0000; done=1.
REQ-040 With DEPTH=4, send 17 bytes -> 4 writes, then ERR with error=1, in_ready=0, cpu_rst=1; a later start clears error.
REQ-041 Random in_valid gaps over 12 bytes -> the 3 words written are identical to those of the gap-free run.
REQ-042 rst asserted after 6 bytes -> exactly 1 write, then IDLE with all outputs at reset values; a restarted load begins at address 0.
REQ-043 start asserted during LOAD -> no effect on addresses or counts.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream load port and instruction-memory write port of the loader.
interface imem_loader_if #(
    parameter int unsigned AW = 10
);
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_last;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    // Loader side.
    modport slave (
        input  start, in_valid, in_data, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata,
               cpu_rst, busy, done, error, words_loaded
    );

    // Host / stream source side.
    modport master (
        output start, in_valid, in_data, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata,
               cpu_rst, busy, done, error, words_loaded
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a big-endian byte stream into a 32-bit instruction memory and holds
// the CPU in reset until a complete image has been written.
module imem_loader #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

    state_t        state_q;
    logic [1:0]    byte_cnt_q;
    logic [31:0]   word_q;
    logic [31:0]   word_d;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [AW:0]   words_q;
    logic          ready_q;
    logic          busy_q;
    logic          done_q;
    logic          error_q;
    logic          cpu_rst_q;
    logic          accept;
    logic          full;

    assign accept = bus.in_valid && ready_q;
    assign full   = (words_q == (AW+1)'(DEPTH));

    // Partial word with the incoming byte merged into its big-endian lane.
    always_comb begin
        word_d = word_q;
        case (byte_cnt_q)
            2'd0:    word_d[31:24] = bus.in_data;
            2'd1:    word_d[23:16] = bus.in_data;
            2'd2:    word_d[15:8]  = bus.in_data;
            default: word_d[7:0]   = bus.in_data;
        endcase
    end

    // Load FSM with registered status, handshake and write-port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= 2'd0;
            word_q     <= 32'd0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            words_q    <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            cpu_rst_q  <= 1'b1;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                LOAD: begin
                    if (accept) begin
                        if (full) begin
                            // Image larger than the memory: stop without writing.
                            state_q    <= ERR;
                            ready_q    <= 1'b0;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                            byte_cnt_q <= 2'd0;
                            word_q     <= 32'd0;
                        end else if (byte_cnt_q == 2'd3 || bus.in_last) begin
                            // Word complete (or zero-filled final word): write it.
                            we_q       <= 1'b1;
                            addr_q     <= words_q[AW-1:0];
                            wdata_q    <= word_d;
                            words_q    <= words_q + {{AW{1'b0}}, 1'b1};
                            byte_cnt_q <= 2'd0;
                            word_q     <= 32'd0;
                            if (bus.in_last) begin
                                state_q <= DONE;
                                ready_q <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            word_q     <= word_d;
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                        end
                    end
                end
                default: begin
                    if (bus.start) begin
                        state_q    <= LOAD;
                        ready_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        cpu_rst_q  <= 1'b1;
                        byte_cnt_q <= 2'd0;
                        word_q     <= 32'd0;
                        words_q    <= '0;
                        addr_q     <= '0;
                    end else if (state_q == DONE) begin
                        // Release the CPU one cycle after the final write.
                        cpu_rst_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready     = ready_q;
    assign bus.imem_we      = we_q;
    assign bus.imem_addr    = addr_q;
    assign bus.imem_wdata   = wdata_q;
    assign bus.cpu_rst      = cpu_rst_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.error        = error_q;
    assign bus.words_loaded = words_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed-random bench for imem_loader with a small memory (DEPTH=4).
module tb_imem_loader;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_loader_if #(.AW(AW)) bus();
    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    // Record every memory write seen between clock edges.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_addr_q.push_back(32'(bus.imem_addr));
            wr_data_q.push_back(bus.imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected word i of an image: byte 4i+k in lane k (MSB first), absent bytes zero.
    function automatic logic [31:0] model_word(input bq_t img, input int i);
        logic [31:0] w = 32'd0;
        for (int k = 0; k < 4; k++)
            if (4*i + k < img.size()) w[31-8*k -: 8] = img[4*i + k];
        return w;
    endfunction

    function automatic int model_nwords(input bq_t img);
        return (img.size() + 3) / 4;
    endfunction

    task automatic check_writes(input string tag, input bq_t img, input int nw);
        check({tag, "_nwrites"}, 32'(wr_data_q.size()), 32'(nw));
        for (int i = 0; i < nw && i < wr_data_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], 32'(i));
            check($sformatf("%s_data%0d", tag, i), wr_data_q[i], model_word(img, i));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_we"},    32'(bus.imem_we), 32'd0);
        check({tag, "_addr"},  32'(bus.imem_addr), 32'd0);
        check({tag, "_wdata"}, bus.imem_wdata, 32'd0);
        check({tag, "_words"}, 32'(bus.words_loaded), 32'd0);
        check({tag, "_busy"},  32'(bus.busy), 32'd0);
        check({tag, "_done"},  32'(bus.done), 32'd0);
        check({tag, "_error"}, 32'(bus.error), 32'd0);
        check({tag, "_cpurst"}, 32'(bus.cpu_rst), 32'd1);
    endtask

    // One-cycle start; optionally with a colliding byte that must not be taken.
    task automatic pulse_start(input bit collide);
        bus.start    = 1'b1;
        bus.in_valid = collide;
        bus.in_data  = 8'hEE;
        bus.in_last  = collide;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Present one byte after 'gap' idle cycles and hold it until accepted.
    task automatic send_byte(input logic [7:0] d, input bit l, input int gap, input bit st);
        int n = 0;
        for (int g = 0; g < gap; g++) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        bus.start    = st;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) check("ready_timeout", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.start    = 1'b0;
    endtask

    function automatic bq_t rand_image(input int len);
        bq_t q;
        for (int i = 0; i < len; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Complete load of an image ending in in_last, checked against the model.
    task automatic run_image(input string tag, input bq_t img, input int max_gap,
                             input int start_at, input bit collide);
        int nw = model_nwords(img);
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start(collide);
        check({tag, "_busy"},  32'(bus.busy), 32'd1);
        check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_err0"},  32'(bus.error), 32'd0);
        check({tag, "_w0"},    32'(bus.words_loaded), 32'd0);
        for (int i = 0; i < img.size(); i++)
            send_byte(img[i], i == img.size() - 1, int'($urandom_range(max_gap, 0)), i == start_at);
        check({tag, "_lastwe"},   32'(bus.imem_we), 32'd1);
        check({tag, "_done"},     32'(bus.done), 32'd1);
        check({tag, "_cpurst_h"}, 32'(bus.cpu_rst), 32'd1);
        check({tag, "_words"},    32'(bus.words_loaded), 32'(nw));
        @(negedge clk);
        check({tag, "_cpurst_l"}, 32'(bus.cpu_rst), 32'd0);
        check({tag, "_we_off"},   32'(bus.imem_we), 32'd0);
        check({tag, "_nerr"},     32'(bus.error), 32'd0);
        check_writes(tag, img, nw);
    endtask

    initial begin
        bq_t img;
        logic [31:0] saved[$];

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Reference two-word program.
        img = '{8'h3C, 8'h01, 8'h00, 8'h00, 8'h34, 8'h21, 8'h00, 8'h04};
        run_image("prog", img, 0, -1, 1'b0);
        check("prog_const0", wr_data_q[0], 32'h3C010000);
        check("prog_const1", wr_data_q[1], 32'h34210004);

        // Partial final word is zero-filled.
        img = '{8'hAA, 8'hBB};
        run_image("part", img, 0, -1, 1'b0);
        check("part_const", wr_data_q[0], 32'hAABB0000);

        // Byte presented together with start is not taken.
        run_image("collide", rand_image(4), 0, -1, 1'b1);

        // start during a load is ignored.
        run_image("restart_ign", rand_image(10), 0, 5, 1'b0);

        // Stream gaps do not change the written words.
        img = rand_image(12);
        run_image("nogap", img, 0, -1, 1'b0);
        saved = wr_data_q;
        run_image("gaps", img, 3, -1, 1'b0);
        for (int i = 0; i < 3; i++)
            check($sformatf("gap_eq%0d", i), wr_data_q[i], saved[i]);

        // Random images of every size up to the full memory.
        for (int t = 0; t < 6; t++)
            run_image($sformatf("rnd%0d", t), rand_image(int'($urandom_range(16, 1))), 2, -1, 1'b0);

        // Exactly DEPTH words completes without error.
        run_image("full", rand_image(16), 1, -1, 1'b0);

        // Overflow: the 17th byte finds the memory full.
        img = rand_image(17);
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start(1'b0);
        for (int i = 0; i < 17; i++) send_byte(img[i], 1'b0, 0, 1'b0);
        check("ovf_error",  32'(bus.error), 32'd1);
        check("ovf_ready",  32'(bus.in_ready), 32'd0);
        check("ovf_cpurst", 32'(bus.cpu_rst), 32'd1);
        check("ovf_busy",   32'(bus.busy), 32'd0);
        check("ovf_done",   32'(bus.done), 32'd0);
        check("ovf_words",  32'(bus.words_loaded), 32'd4);
        @(negedge clk);
        check("ovf_we",     32'(bus.imem_we), 32'd0);
        check_writes("ovf", img, 4);
        run_image("after_ovf", rand_image(5), 0, -1, 1'b0);

        // Reset mid-load, asserted together with start and a byte.
        img = rand_image(6);
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start(1'b0);
        for (int i = 0; i < 6; i++) send_byte(img[i], 1'b0, 0, 1'b0);
        rst          = 1'b1;
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check_reset_outputs("midrst");
        @(negedge clk);
        check_reset_outputs("midrst_idle");
        check_writes("midrst", img, 1);
        run_image("after_rst", rand_image(7), 1, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
